// File: rtl/spi_frame_rx_if.sv
// Serial inputs and committed-word outputs of the configuration-bridge receive deserializer.
interface spi_frame_rx_if #(
  parameter int DYN_WIDTH  = 16,
  parameter int STAT_WIDTH = 88
);
  logic                  SCLK_IN;
  logic                  SEL_IN;
  logic                  MOSI_IN;
  logic [DYN_WIDTH-1:0]  DYN_REG;
  logic [STAT_WIDTH-1:0] STAT_REG;
  logic                  DYN_VALID;
  logic                  STAT_VALID;
  logic                  FRAME_ERR;
  logic [7:0]            ERR_COUNT;

  modport master (
    output SCLK_IN, SEL_IN, MOSI_IN,
    input  DYN_REG, STAT_REG, DYN_VALID, STAT_VALID, FRAME_ERR, ERR_COUNT
  );

  modport slave (
    input  SCLK_IN, SEL_IN, MOSI_IN,
    output DYN_REG, STAT_REG, DYN_VALID, STAT_VALID, FRAME_ERR, ERR_COUNT
  );
endinterface

// File: rtl/spi_frame_rx.sv
// Oversampling receive deserializer: rebuilds the dynamic and static configuration words
// from the gated serial clock and flags malformed or stalled frames.
//
//   state      | meaning
//   IDLE       | no frame open; an edge with SEL=0 here is stray
//   DYN_SHIFT  | collecting dynamic word bits (SEL=1)
//   STAT_SHIFT | collecting static word bits (SEL=0)
module spi_frame_rx #(
  parameter int                   DYN_WIDTH      = 16,
  parameter int                   STAT_WIDTH     = 88,
  parameter int                   TIMEOUT_CYCLES = 1024,
  parameter logic [DYN_WIDTH-1:0] DYN_RESET_VAL  = '0,
  parameter logic [STAT_WIDTH-1:0] STAT_RESET_VAL = '0
) (
  input logic           CLK,
  input logic           RST_N,
  spi_frame_rx_if.slave bus
);
  localparam int             TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]     DYN_LAST  = 7'(DYN_WIDTH - 1);
  localparam logic [6:0]     STAT_LAST = 7'(STAT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DYN_SHIFT, STAT_SHIFT} state_t;

  state_t                state;
  logic                  sclk_s1, sclk_s2, sclk_s3;
  logic                  sel_s1, sel_s2;
  logic                  mosi_s1, mosi_s2;
  // Only STAT_WIDTH-1 history bits are needed: the last bit comes straight from mosi_s2.
  logic [STAT_WIDTH-2:0] shreg;
  logic [6:0]            cnt;
  logic [TW-1:0]         tcnt;
  logic [DYN_WIDTH-1:0]  dyn_reg;
  logic [STAT_WIDTH-1:0] stat_reg;
  logic                  dyn_valid, stat_valid, frame_err;
  logic [7:0]            err_count;

  logic                  bit_stb;
  logic                  err_now;
  logic [STAT_WIDTH-2:0] shreg_next;

  always_comb begin
    bit_stb    = sclk_s2 & ~sclk_s3;
    shreg_next = {shreg[STAT_WIDTH-3:0], mosi_s2};
    err_now    = 1'b0;
    case (state)
      IDLE:       err_now = bit_stb & ~sel_s2;
      DYN_SHIFT:  err_now = bit_stb ? ~sel_s2 : (tcnt == TO_LAST);
      STAT_SHIFT: err_now = bit_stb ?  sel_s2 : (tcnt == TO_LAST);
      default:    err_now = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sclk_s1    <= 1'b0;
      sclk_s2    <= 1'b0;
      sclk_s3    <= 1'b0;
      sel_s1     <= 1'b0;
      sel_s2     <= 1'b0;
      mosi_s1    <= 1'b0;
      mosi_s2    <= 1'b0;
      shreg      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      dyn_reg    <= DYN_RESET_VAL;
      stat_reg   <= STAT_RESET_VAL;
      dyn_valid  <= 1'b0;
      stat_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      sclk_s1    <= bus.SCLK_IN;
      sclk_s2    <= sclk_s1;
      sclk_s3    <= sclk_s2;
      sel_s1     <= bus.SEL_IN;
      sel_s2     <= sel_s1;
      mosi_s1    <= bus.MOSI_IN;
      mosi_s2    <= mosi_s1;
      dyn_valid  <= 1'b0;
      stat_valid <= 1'b0;
      frame_err  <= err_now;
      if (err_now && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (bit_stb && sel_s2) begin
            shreg <= shreg_next;
            cnt   <= 7'd1;
            state <= DYN_SHIFT;
          end
        end
        DYN_SHIFT: begin
          if (err_now) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= IDLE;
          end else if (bit_stb) begin
            tcnt  <= '0;
            shreg <= shreg_next;
            if (cnt == DYN_LAST) begin
              dyn_reg   <= {shreg[DYN_WIDTH-2:0], mosi_s2};
              dyn_valid <= 1'b1;
              cnt       <= '0;
              state     <= STAT_SHIFT;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STAT_SHIFT: begin
          if (err_now) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= IDLE;
          end else if (bit_stb) begin
            tcnt  <= '0;
            shreg <= shreg_next;
            if (cnt == STAT_LAST) begin
              stat_reg   <= {shreg, mosi_s2};
              stat_valid <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          tcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.DYN_REG    = dyn_reg;
  assign bus.STAT_REG   = stat_reg;
  assign bus.DYN_VALID  = dyn_valid;
  assign bus.STAT_VALID = stat_valid;
  assign bus.FRAME_ERR  = frame_err;
  assign bus.ERR_COUNT  = err_count;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: full frames, aborts, timeout, mid-frame reset,
// stray edges with counter saturation, and back-to-back commit latency.
module tb_spi_frame_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   errors = 0;

  int   dyn_v_cnt = 0;
  int   stat_v_cnt = 0;
  int   err_mon_cnt = 0;

  localparam logic [15:0] DEF_DYN  = 16'hABC6;
  localparam logic [87:0] DEF_STAT = 88'h123456789ABCDEF1234567;

  spi_frame_rx_if #(.DYN_WIDTH(16), .STAT_WIDTH(88)) bus ();

  spi_frame_rx #(
    .DYN_WIDTH(16), .STAT_WIDTH(88), .TIMEOUT_CYCLES(1024),
    .DYN_RESET_VAL(16'h0000), .STAT_RESET_VAL(88'h0)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.DYN_VALID === 1'b1)  dyn_v_cnt++;
    if (bus.STAT_VALID === 1'b1) stat_v_cnt++;
    if (bus.FRAME_ERR === 1'b1)  err_mon_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic sel, input logic b);
    bus.SEL_IN  = sel;
    bus.MOSI_IN = b;
    repeat (3) tick();
    bus.SCLK_IN = 1'b1;
    repeat (4) tick();
    bus.SCLK_IN = 1'b0;
  endtask

  task automatic send_dyn(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) send_bit(1'b1, w[i]);
  endtask

  task automatic send_stat(input logic [87:0] w, input int nbits);
    for (int i = 87; i > 87 - nbits; i--) send_bit(1'b0, w[i]);
  endtask

  task automatic apply_reset();
    bus.SCLK_IN = 1'b0;
    bus.SEL_IN  = 1'b0;
    bus.MOSI_IN = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (bus.DYN_REG !== 16'h0000) begin errors++; $display("FAIL reset_dyn_reg: got %h want 0000", bus.DYN_REG); end
    tests++; if (bus.STAT_REG !== 88'h0) begin errors++; $display("FAIL reset_stat_reg: got %h want 0", bus.STAT_REG); end
    tests++; if (bus.DYN_VALID !== 1'b0 || bus.STAT_VALID !== 1'b0 || bus.FRAME_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: dv=%b sv=%b fe=%b want 0 0 0", bus.DYN_VALID, bus.STAT_VALID, bus.FRAME_ERR); end
    tests++; if (bus.ERR_COUNT !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", bus.ERR_COUNT); end
  endtask

  task automatic test_default_frame();
    int d0, s0, e0;
    d0 = dyn_v_cnt; s0 = stat_v_cnt; e0 = err_mon_cnt;
    send_dyn(DEF_DYN, 16);
    send_stat(DEF_STAT, 88);
    repeat (4) tick();
    tests++; if (dyn_v_cnt - d0 != 1) begin errors++; $display("FAIL default_dyn_valid_count: got %0d want 1", dyn_v_cnt - d0); end
    tests++; if (stat_v_cnt - s0 != 1) begin errors++; $display("FAIL default_stat_valid_count: got %0d want 1", stat_v_cnt - s0); end
    tests++; if (err_mon_cnt - e0 != 0) begin errors++; $display("FAIL default_frame_err: got %0d want 0", err_mon_cnt - e0); end
    tests++; if (bus.DYN_REG !== 16'hABC6) begin errors++; $display("FAIL default_dyn_reg: got %h want abc6", bus.DYN_REG); end
    tests++; if (bus.STAT_REG !== 88'h123456789ABCDEF1234567) begin errors++; $display("FAIL default_stat_reg: got %h want 123456789abcdef1234567", bus.STAT_REG); end
  endtask

  task automatic test_sel_drop();
    int d0, e0;
    apply_reset();
    d0 = dyn_v_cnt; e0 = err_mon_cnt;
    send_dyn(DEF_DYN, 10);
    send_bit(1'b0, 1'b1);
    tick();
    tests++; if (err_mon_cnt - e0 != 1) begin errors++; $display("FAIL seldrop_frame_err: got %0d want 1", err_mon_cnt - e0); end
    tests++; if (bus.ERR_COUNT !== 8'd1) begin errors++; $display("FAIL seldrop_err_count: got %0d want 1", bus.ERR_COUNT); end
    tests++; if (bus.DYN_REG !== 16'h0000 || dyn_v_cnt != d0) begin
      errors++; $display("FAIL seldrop_dyn_kept: got %h (valids %0d) want 0000 (0)", bus.DYN_REG, dyn_v_cnt - d0); end
    send_dyn(16'h5A3C, 16);
    send_stat(88'hFEDCBA9876543210ABCDEF, 88);
    repeat (4) tick();
    tests++; if (bus.DYN_REG !== 16'h5A3C) begin errors++; $display("FAIL seldrop_next_dyn: got %h want 5a3c", bus.DYN_REG); end
    tests++; if (bus.STAT_REG !== 88'hFEDCBA9876543210ABCDEF) begin errors++; $display("FAIL seldrop_next_stat: got %h want fedcba9876543210abcdef", bus.STAT_REG); end
    tests++; if (err_mon_cnt - e0 != 1) begin errors++; $display("FAIL seldrop_next_no_err: got %0d want 1", err_mon_cnt - e0); end
  endtask

  task automatic test_timeout();
    int s0, e0, err_at;
    apply_reset();
    s0 = stat_v_cnt; e0 = err_mon_cnt;
    send_dyn(DEF_DYN, 16);
    send_stat(DEF_STAT, 40);
    err_at = -1;
    // Last SCLK rise was driven 4 edges before this loop; expiry lands 1024 edges after its bit registers.
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus.FRAME_ERR === 1'b1 && err_at < 0) err_at = i;
    end
    tests++; if (err_at != 1022) begin errors++; $display("FAIL timeout_edge: got loop index %0d want 1022", err_at); end
    tests++; if (err_mon_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err_pulses: got %0d want 1", err_mon_cnt - e0); end
    tests++; if (bus.DYN_REG !== 16'hABC6) begin errors++; $display("FAIL timeout_dyn_kept: got %h want abc6", bus.DYN_REG); end
    tests++; if (bus.STAT_REG !== 88'h0 || stat_v_cnt != s0) begin
      errors++; $display("FAIL timeout_stat_kept: got %h (valids %0d) want 0 (0)", bus.STAT_REG, stat_v_cnt - s0); end
    tests++; if (bus.ERR_COUNT !== 8'd1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", bus.ERR_COUNT); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    send_bit(1'b0, 1'b0);
    send_dyn(16'h1234, 16);
    send_stat(DEF_STAT, 50);
    tick();
    tests++; if (bus.ERR_COUNT !== 8'd1 || bus.DYN_REG !== 16'h1234) begin
      errors++; $display("FAIL midreset_pre: err_count %0d dyn %h want 1 1234", bus.ERR_COUNT, bus.DYN_REG); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (bus.DYN_REG !== 16'h0000 || bus.STAT_REG !== 88'h0) begin
      errors++; $display("FAIL midreset_regs: dyn %h stat %h want 0000 0", bus.DYN_REG, bus.STAT_REG); end
    tests++; if (bus.ERR_COUNT !== 8'd0 || bus.FRAME_ERR !== 1'b0 || bus.DYN_VALID !== 1'b0 || bus.STAT_VALID !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: err_count %0d fe %b dv %b sv %b want 0 0 0 0", bus.ERR_COUNT, bus.FRAME_ERR, bus.DYN_VALID, bus.STAT_VALID); end
    tick();
    send_dyn(DEF_DYN, 16);
    send_stat(DEF_STAT, 88);
    repeat (4) tick();
    tests++; if (bus.DYN_REG !== 16'hABC6 || bus.STAT_REG !== 88'h123456789ABCDEF1234567) begin
      errors++; $display("FAIL midreset_next_frame: dyn %h stat %h want abc6 123456789abcdef1234567", bus.DYN_REG, bus.STAT_REG); end
    tests++; if (bus.ERR_COUNT !== 8'd0) begin errors++; $display("FAIL midreset_next_err_count: got %0d want 0", bus.ERR_COUNT); end
  endtask

  task automatic test_stray();
    int d0, s0, e0;
    apply_reset();
    d0 = dyn_v_cnt; s0 = stat_v_cnt; e0 = err_mon_cnt;
    send_bit(1'b0, 1'b1);
    tick();
    tests++; if (err_mon_cnt - e0 != 1 || bus.ERR_COUNT !== 8'd1) begin
      errors++; $display("FAIL stray_single: pulses %0d err_count %0d want 1 1", err_mon_cnt - e0, bus.ERR_COUNT); end
    for (int i = 0; i < 299; i++) send_bit(1'b0, i[0]);
    tick();
    tests++; if (bus.ERR_COUNT !== 8'd255) begin errors++; $display("FAIL stray_saturate: got %0d want 255", bus.ERR_COUNT); end
    tests++; if (err_mon_cnt - e0 != 300) begin errors++; $display("FAIL stray_pulses: got %0d want 300", err_mon_cnt - e0); end
    tests++; if (dyn_v_cnt != d0 || stat_v_cnt != s0) begin
      errors++; $display("FAIL stray_no_valid: dyn %0d stat %0d want 0 0", dyn_v_cnt - d0, stat_v_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int d0, s0, lat;
    apply_reset();
    d0 = dyn_v_cnt; s0 = stat_v_cnt;
    send_dyn(16'h0001, 16);
    send_stat(88'h0, 88);
    tests++; if (bus.DYN_REG !== 16'h0001) begin errors++; $display("FAIL b2b_first_dyn: got %h want 0001", bus.DYN_REG); end
    send_dyn(16'hFFFF, 15);
    bus.SEL_IN = 1'b1;
    bus.MOSI_IN = 1'b1;
    repeat (3) tick();
    bus.SCLK_IN = 1'b1;
    lat = -1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.DYN_VALID === 1'b1 && lat < 0) lat = i;
    end
    bus.SCLK_IN = 1'b0;
    tests++; if (lat != 3) begin errors++; $display("FAIL b2b_commit_latency: got %0d edges after drive want 3", lat); end
    send_stat(88'hA5A5A5A5A5A5A5A5A5A5A5, 88);
    repeat (4) tick();
    tests++; if (dyn_v_cnt - d0 != 2) begin errors++; $display("FAIL b2b_dyn_valid_count: got %0d want 2", dyn_v_cnt - d0); end
    tests++; if (bus.DYN_REG !== 16'hFFFF) begin errors++; $display("FAIL b2b_final_dyn: got %h want ffff", bus.DYN_REG); end
    tests++; if (stat_v_cnt - s0 != 2 || bus.STAT_REG !== 88'hA5A5A5A5A5A5A5A5A5A5A5) begin
      errors++; $display("FAIL b2b_stat: valids %0d reg %h want 2 a5a5a5a5a5a5a5a5a5a5a5", stat_v_cnt - s0, bus.STAT_REG); end
  endtask

  initial begin
    bus.SCLK_IN = 1'b0;
    bus.SEL_IN  = 1'b0;
    bus.MOSI_IN = 1'b0;
    test_reset();
    test_default_frame();
    test_sel_drop();
    test_timeout();
    test_mid_reset();
    test_stray();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Receive-side deserializer for the configuration bridge. It samples the gated serial clock, SEL and MOSI produced by the register-select FSM, and rebuilds the 16-bit dynamic word and the 88-bit static word. Each word is committed to a parallel output register with a one-cycle valid strobe. The block runs entirely in the fast CLK domain, oversampling the slow gated serial clock, and flags malformed or stalled frames.

## Interface
- DYN_WIDTH, 16, dynamic word length in bits
- STAT_WIDTH, 88, static word length in bits
- TIMEOUT_CYCLES, 1024, CLK cycles without a serial-clock rising edge before an open frame is aborted
- DYN_RESET_VAL, 16'h0000, DYN_REG value after reset
- STAT_RESET_VAL, 88'h0, STAT_REG value after reset

Ports:
- CLK  in  1  fast system clock; the only clock in the block
- RST_N  in  1  reset, synchronous and active-low
- SCLK_IN  in  1  gated serial clock from the FSM; asynchronous to CLK; high and low phases each ≥ 3 CLK cycles
- SEL_IN  in  1  1 = dynamic word bits, 0 = static word bits / idle
- MOSI_IN  in  1  serial data, MSB first
- DYN_REG  out  DYN_WIDTH  last committed dynamic word
- STAT_REG  out  STAT_WIDTH  last committed static word
- DYN_VALID  out  1  one-cycle strobe; DYN_REG updated this cycle
- STAT_VALID  out  1  one-cycle strobe; STAT_REG updated this cycle
- FRAME_ERR  out  1  one-cycle strobe on any frame error
- ERR_COUNT  out  8  saturating error counter

## Operation
- SCLK_IN, SEL_IN and MOSI_IN each pass through 2 sync flops (s1, s2); SCLK has a third flop (s3).
- Bit strobe = sclk_s2 & ~sclk_s3. Data and select are taken from sel_s2 and mosi_s2.
- Shift rule: shreg <= {shreg[W-2:0], mosi_s2}; bit counter is 7 bits wide.
- States: IDLE, DYN_SHIFT, STAT_SHIFT.
- IDLE:
  - strobe with sel=1: shift first bit, cnt=1, go to DYN_SHIFT.
  - strobe with sel=0: stray edge; FRAME_ERR, stay in IDLE.
- DYN_SHIFT:
  - strobe with sel=1: shift, cnt++.
  - On the 16th bit: commit DYN_REG = {shreg[14:0], mosi}, pulse DYN_VALID, set cnt=0, go to STAT_SHIFT.
  - strobe with sel=0 before bit 16: abort.
- STAT_SHIFT:
  - strobe with sel=0: shift, cnt++.
  - On the 88th bit: commit STAT_REG, pulse STAT_VALID, go to IDLE.
  - strobe with sel=1: abort. The already-committed DYN_REG is kept.
- Abort: discard the partial word, pulse FRAME_ERR, increment ERR_COUNT, go to IDLE.
- ERR_COUNT increments on every FRAME_ERR and saturates at 255.
- Timeout counter:
  - counts CLK cycles in DYN_SHIFT/STAT_SHIFT and clears on every strobe.
  - reaching TIMEOUT_CYCLES-1 aborts the frame.
  - held at 0 in IDLE.
- Committed registers hold their value until the next commit or reset. A failed frame never corrupts the committed registers.

## Timing
- Reset (synchronous, RST_N low at a CLK edge) sets:
  - all sync flops and the shift register to 0
  - state IDLE, cnt 0, timeout counter 0
  - DYN_REG=DYN_RESET_VAL, STAT_REG=STAT_RESET_VAL
  - DYN_VALID=STAT_VALID=FRAME_ERR=0, ERR_COUNT=0
- Reset mid-frame discards the partial word; both output registers return to their reset values.
- Latency: SCLK_IN high first captured at CLK edge k → shift, commit, strobes and FRAME_ERR all register at edge k+2.
- Strobes stay high for exactly one CLK cycle.
- Dynamic and static commits never occur in the same cycle; they are ≥ 1 serial period apart.
- Strobe and timeout expiry in the same cycle: the strobe wins. The bit is accepted and the counter clears.
- SEL change coincident with an SCLK rise: resolved by the sync-flop sample. Validity is the upstream FSM's obligation (SEL is stable ≥ 3 CLK before SCLK rises).
- No back-pressure: consumers must read DYN_REG/STAT_REG on or after the valid strobe.

## Test plan
- Default frame: 16 bits 0xABC6 with SEL=1, then 88 bits 0x123456789ABCDEF1234567 with SEL=0. Required:
  - DYN_VALID once, DYN_REG=16'hABC6
  - STAT_VALID once, STAT_REG=88'h123456789ABCDEF1234567
  - FRAME_ERR never asserted
- Drop SEL after 10 dynamic bits → FRAME_ERR, ERR_COUNT=1, DYN_REG unchanged (0x0000), state IDLE. A following full frame is received correctly.
- Stop SCLK_IN after 40 static bits for 1100 CLK cycles → FRAME_ERR at cycle 1024 of the stall. DYN_REG keeps 0xABC6, STAT_REG unchanged, ERR_COUNT=1.
- Assert RST_N low for one edge after 50 static bits → all outputs at reset values. The next full frame commits correctly.
- SCLK_IN pulse with SEL=0 while idle → FRAME_ERR, no valid strobes. 300 such pulses → ERR_COUNT saturates at 255.
- Two back-to-back frames with dynamic words 0x0001 then 0xFFFF → DYN_VALID twice, final DYN_REG=16'hFFFF. Commit lands exactly 2 CLK edges after the 16th SCLK rise is first sampled.
